// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the 1:4 demux round-robin scheduler.
//   NUM_CH        number of demux output channels
//   ch_idx_t      channel index, also the {sel1,sel0} encoding
//   sched_state_t scheduler FSM state
//   LAST_RST      reset value of the round-robin pointer, so the first grant
//                 after reset lands on channel 0
package demux_sched_pkg;

   localparam int NUM_CH = 4;

   typedef logic [1:0] ch_idx_t;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } sched_state_t;

   localparam ch_idx_t LAST_RST = 2'd3;

endpackage

// File: rtl/rr_pick4.sv
// Rotate-priority picker over four channels.
// Ports:
//   mask       in  4  candidate channels (bit n = channel n)
//   start      in  2  search begins just after this channel
//   exclude_en in  1  when set, 'start' itself is never picked
//   idx        out 2  first masked channel in order start+1..start+3, start
//   found      out 1  a channel was picked (idx valid)
module rr_pick4
   import demux_sched_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  ch_idx_t           start,
   input  logic              exclude_en,
   output ch_idx_t           idx,
   output logic              found
);

   ch_idx_t cand;

   always_comb begin
      idx   = start;
      found = 1'b0;
      cand  = start;
      // k = 4 wraps back onto 'start' in the 2-bit index space.
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = start + ch_idx_t'(k);
         if (!found && mask[cand] && !(k == NUM_CH && exclude_en)) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux1_4_sched.sv
// Round-robin dispatch controller in front of the demux1_4 datapath.
// Takes one valid/ready input stream, holds each accepted beat in a one-entry
// output register and presents it on exactly one of four channels, chosen in
// round-robin order among the channels enabled by en_mask.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous, active-high reset
//   in_data      in   DW  input beat
//   in_valid     in   1   input beat present
//   in_ready     out  1   a beat can be taken this cycle (combinational)
//   en_mask      in   4   per-channel enable
//   sel0/sel1    out  1   demux select, channel = {sel1,sel0}
//   out_data     out  DW  held beat, fanned out to every channel
//   out_valid    out  4   one-hot valid for the selected channel
//   out_ready    in   4   per-channel accept
//   retarget_cnt out  8   saturating count of timeout retargets
//
// Build option: DEMUX_SCHED_TIMEOUT_EN adds a hold timer that re-points a
// stalled beat to the next enabled channel after TIMEOUT hold cycles. Without
// it a held beat waits indefinitely and retarget_cnt is tied to 0.
//
// state | meaning
// ------+---------------------------------------------------
// EMPTY | no beat held, out_valid = 0
// HOLD  | beat held in out_data, out_valid[{sel1,sel0}] = 1
module demux1_4_sched
   import demux_sched_pkg::*;
#(
   parameter int DW      = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DW-1:0]     in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NUM_CH-1:0] en_mask,
   output logic              sel0,
   output logic              sel1,
   output logic [DW-1:0]     out_data,
   output logic [NUM_CH-1:0] out_valid,
   input  logic [NUM_CH-1:0] out_ready,
   output logic [7:0]        retarget_cnt
);

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("demux1_4_sched: TIMEOUT must be within 2..255");
   end

   sched_state_t  state_q, state_d;
   ch_idx_t       sel_q, sel_d;
   ch_idx_t       last_q, last_d;
   logic [DW-1:0] data_q, data_d;

   logic    hold;
   logic    fire_out;
   logic    fire_in;
   ch_idx_t acc_idx;
   logic    acc_found;

   assign hold     = (state_q == HOLD);
   assign fire_out = hold && out_ready[sel_q];

   // With exclude off the picker finds a channel exactly when any bit of
   // en_mask is set, so acc_found doubles as the "something enabled" term.
   rr_pick4 u_acc_pick (
      .mask       (en_mask),
      .start      (last_q),
      .exclude_en (1'b0),
      .idx        (acc_idx),
      .found      (acc_found)
   );

   assign in_ready = acc_found && (!hold || fire_out);
   assign fire_in  = in_valid && in_ready;

`ifdef DEMUX_SCHED_TIMEOUT_EN
   // Down-counter reloaded with TIMEOUT-1 on every load; reaching zero in a
   // hold cycle without a fire means the beat has waited TIMEOUT cycles.
   localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);

   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [7:0] rtc_q, rtc_d;
   ch_idx_t    rt_idx;
   logic       rt_found;
   logic       timeout_tc;

   rr_pick4 u_rt_pick (
      .mask       (en_mask),
      .start      (sel_q),
      .exclude_en (1'b1),
      .idx        (rt_idx),
      .found      (rt_found)
   );

   assign timeout_tc = hold && !fire_out && (hold_cnt_q == 8'd0);

   always_comb begin
      hold_cnt_d = hold_cnt_q;
      rtc_d      = rtc_q;
      if (!hold || fire_out) begin
         hold_cnt_d = TO_LOAD;
      end else if (timeout_tc) begin
         hold_cnt_d = TO_LOAD;
         if (rt_found && rtc_q != 8'hFF) begin
            rtc_d = rtc_q + 8'd1;
         end
      end else begin
         hold_cnt_d = hold_cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_q <= TO_LOAD;
         rtc_q      <= 8'd0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         rtc_q      <= rtc_d;
      end
   end

   assign retarget_cnt = rtc_q;
`else
   assign retarget_cnt = 8'd0;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      data_d  = data_q;
      if (fire_in) begin
         // Covers both the EMPTY load and the back-to-back reload on fire_out.
         state_d = HOLD;
         sel_d   = acc_idx;
         last_d  = acc_idx;
         data_d  = in_data;
      end else if (fire_out) begin
         state_d = EMPTY;
`ifdef DEMUX_SCHED_TIMEOUT_EN
      end else if (timeout_tc && rt_found) begin
         sel_d  = rt_idx;
         last_d = rt_idx;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         sel_q   <= '0;
         last_q  <= LAST_RST;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   assign sel0      = sel_q[0];
   assign sel1      = sel_q[1];
   assign out_data  = data_q;
   assign out_valid = hold ? (NUM_CH'(1) << sel_q) : '0;

endmodule

// File: tb/tb_demux1_4_sched.sv
module tb_demux1_4_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] en_mask;
   logic       sel0, sel1;
   logic [7:0] out_data;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [7:0] retarget_cnt;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   demux1_4_sched #(.DW(8), .TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .en_mask      (en_mask),
      .sel0         (sel0),
      .sel1         (sel1),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .retarget_cnt (retarget_cnt)
   );

   typedef struct {
      logic       rst;
      logic       iv;
      logic [7:0] id;
      logic [3:0] en;
      logic [3:0] ordy;
      bit         chk;
      logic       eir;
      logic [3:0] eov;
      logic [1:0] esel;
      logic [7:0] edat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic iv, logic [7:0] id, logic [3:0] en,
                               logic [3:0] ordy, bit chk, logic eir, logic [3:0] eov,
                               logic [1:0] esel, logic [7:0] edat);
      vec_t v;
      v.rst = r; v.iv = iv; v.id = id; v.en = en; v.ordy = ordy;
      v.chk = chk; v.eir = eir; v.eov = eov; v.esel = esel; v.edat = edat;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [7:0] id,
                        input logic [3:0] en, input logic [3:0] ordy);
      rst = r; in_valid = iv; in_data = id; en_mask = en; out_ready = ordy;
   endtask

   task automatic check_outs(input string tag, input logic eir, input logic [3:0] eov,
                             input logic [1:0] esel, input logic [7:0] edat,
                             input logic [7:0] ertc);
      n_vec++;
      check({tag, " in_ready"},     8'(in_ready),     8'(eir));
      check({tag, " out_valid"},    8'(out_valid),    8'(eov));
      check({tag, " sel"},          8'({sel1, sel0}), 8'(esel));
      check({tag, " out_data"},     out_data,         edat);
      check({tag, " retarget_cnt"}, retarget_cnt,     ertc);
   endtask

   // Inputs change 1 time unit after the rising edge, outputs are sampled
   // 3 units later, well clear of either edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b1, 1'b0, 8'h00, 4'b1111, 4'b1111);

      // rst iv  id     en       ordy     chk  ir   ov       sel   data
      // Reset, then four back-to-back beats across all channels.
      vecs.push_back(mk(1, 0, 8'h00, 4'b1111, 4'b1111, 0, 0, 4'b0000, 2'd0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 4'b1111, 4'b1111, 1, 1, 4'b0000, 2'd0, 8'h00));
      vecs.push_back(mk(0, 1, 8'hA0, 4'b1111, 4'b1111, 1, 1, 4'b0000, 2'd0, 8'h00));
      vecs.push_back(mk(0, 1, 8'hA1, 4'b1111, 4'b1111, 1, 1, 4'b0001, 2'd0, 8'hA0));
      vecs.push_back(mk(0, 1, 8'hA2, 4'b1111, 4'b1111, 1, 1, 4'b0010, 2'd1, 8'hA1));
      vecs.push_back(mk(0, 1, 8'hA3, 4'b1111, 4'b1111, 1, 1, 4'b0100, 2'd2, 8'hA2));
      vecs.push_back(mk(0, 0, 8'h00, 4'b1111, 4'b1111, 1, 1, 4'b1000, 2'd3, 8'hA3));
      // Mask 0101: six beats alternate channels 0 and 2.
      vecs.push_back(mk(0, 0, 8'h00, 4'b0101, 4'b1111, 1, 1, 4'b0000, 2'd3, 8'hA3));
      vecs.push_back(mk(0, 1, 8'hB0, 4'b0101, 4'b1111, 1, 1, 4'b0000, 2'd3, 8'hA3));
      vecs.push_back(mk(0, 1, 8'hB1, 4'b0101, 4'b1111, 1, 1, 4'b0001, 2'd0, 8'hB0));
      vecs.push_back(mk(0, 1, 8'hB2, 4'b0101, 4'b1111, 1, 1, 4'b0100, 2'd2, 8'hB1));
      vecs.push_back(mk(0, 1, 8'hB3, 4'b0101, 4'b1111, 1, 1, 4'b0001, 2'd0, 8'hB2));
      vecs.push_back(mk(0, 1, 8'hB4, 4'b0101, 4'b1111, 1, 1, 4'b0100, 2'd2, 8'hB3));
      vecs.push_back(mk(0, 1, 8'hB5, 4'b0101, 4'b1111, 1, 1, 4'b0001, 2'd0, 8'hB4));
      vecs.push_back(mk(0, 0, 8'h00, 4'b0101, 4'b1111, 1, 1, 4'b0100, 2'd2, 8'hB5));
      // Empty mask blocks acceptance.
      vecs.push_back(mk(0, 0, 8'h00, 4'b1111, 4'b1111, 1, 1, 4'b0000, 2'd2, 8'hB5));
      vecs.push_back(mk(0, 1, 8'hCC, 4'b0000, 4'b1111, 1, 0, 4'b0000, 2'd2, 8'hB5));
      vecs.push_back(mk(0, 0, 8'h00, 4'b1111, 4'b1111, 1, 1, 4'b0000, 2'd2, 8'hB5));
      // Stall: 0x55 held six cycles, then fired together with a reload.
      vecs.push_back(mk(1, 0, 8'h00, 4'b0001, 4'b0000, 0, 0, 4'b0000, 2'd0, 8'h00));
      vecs.push_back(mk(0, 1, 8'h55, 4'b0001, 4'b0000, 1, 1, 4'b0000, 2'd0, 8'h00));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 1, 8'h66, 4'b0001, 4'b0000, 1, 0, 4'b0001, 2'd0, 8'h55));
      vecs.push_back(mk(0, 1, 8'h66, 4'b0001, 4'b0001, 1, 1, 4'b0001, 2'd0, 8'h55));
      vecs.push_back(mk(0, 0, 8'h00, 4'b0001, 4'b0001, 1, 1, 4'b0001, 2'd0, 8'h66));
      // Mask bit of the held channel cleared mid-hold.
      vecs.push_back(mk(1, 0, 8'h00, 4'b1111, 4'b0000, 0, 0, 4'b0000, 2'd0, 8'h00));
      vecs.push_back(mk(0, 1, 8'h77, 4'b1111, 4'b0000, 1, 1, 4'b0000, 2'd0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 4'b1110, 4'b0000, 1, 0, 4'b0001, 2'd0, 8'h77));
      vecs.push_back(mk(0, 1, 8'h88, 4'b1110, 4'b0001, 1, 1, 4'b0001, 2'd0, 8'h77));
      vecs.push_back(mk(0, 0, 8'h00, 4'b1110, 4'b1111, 1, 1, 4'b0010, 2'd1, 8'h88));
      // Reset mid-hold discards the beat and restarts the rotation at 0.
      vecs.push_back(mk(0, 1, 8'h99, 4'b1111, 4'b0000, 1, 1, 4'b0000, 2'd1, 8'h88));
      vecs.push_back(mk(1, 0, 8'h00, 4'b1111, 4'b0000, 1, 0, 4'b0100, 2'd2, 8'h99));
      vecs.push_back(mk(0, 1, 8'hAA, 4'b1111, 4'b0000, 1, 1, 4'b0000, 2'd0, 8'h00));
      vecs.push_back(mk(0, 0, 8'h00, 4'b1111, 4'b1111, 1, 1, 4'b0001, 2'd0, 8'hAA));

      next_cycle();
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].en, vecs[i].ordy);
         #3;
         if (vecs[i].chk)
            check_outs($sformatf("vec%0d", i), vecs[i].eir, vecs[i].eov,
                       vecs[i].esel, vecs[i].edat, 8'd0);
         next_cycle();
      end

      // Timeout: channel 0 never ready, every other channel ready.
      drive(1'b1, 1'b0, 8'h00, 4'b1111, 4'b1110);
      next_cycle();
      drive(1'b0, 1'b1, 8'hBB, 4'b1111, 4'b1110);
      #3;
      check_outs("to_load", 1'b1, 4'b0000, 2'd0, 8'h00, 8'd0);
      next_cycle();
      drive(1'b0, 1'b0, 8'h00, 4'b1111, 4'b1110);
      for (int i = 1; i <= 4; i++) begin
         #3;
         check_outs($sformatf("to_hold%0d", i), 1'b0, 4'b0001, 2'd0, 8'hBB, 8'd0);
         next_cycle();
      end
      #3;
`ifdef DEMUX_SCHED_TIMEOUT_EN
      check_outs("to_moved", 1'b1, 4'b0010, 2'd1, 8'hBB, 8'd1);
      next_cycle();
      #3;
      check_outs("to_drained", 1'b1, 4'b0000, 2'd1, 8'hBB, 8'd1);
`else
      check_outs("to_stays", 1'b0, 4'b0001, 2'd0, 8'hBB, 8'd0);
      next_cycle();
      #3;
      check_outs("to_stays2", 1'b0, 4'b0001, 2'd0, 8'hBB, 8'd0);
      next_cycle();
      drive(1'b0, 1'b0, 8'h00, 4'b1111, 4'b1111);
      #3;
      check_outs("to_release", 1'b1, 4'b0001, 2'd0, 8'hBB, 8'd0);
      next_cycle();
      #3;
      check_outs("to_empty", 1'b1, 4'b0000, 2'd0, 8'hBB, 8'd0);
`endif
      next_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // out_valid must never carry more than one set bit.
   always @(negedge clk) begin
      if (rst === 1'b0 && !$onehot0(out_valid)) begin
         n_bad++;
         $display("FAIL onehot out_valid: got %b, expected at most one bit", out_valid);
      end
   end

endmodule
